dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the core's load/store path (port 0) and a loader/debug master (port 1). It grants one access per cycle with round-robin fairness, supports locked bursts capped by a beat counter, and returns one registered response per accepted access. It sits between the requesters and the data memory, whose reads are combinational and whose writes commit on the clock edge.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_rr_pick.sv | 31 +++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Ownership state: free, or locked to one requester.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  localparam int unsigned MAX_BURST_DEFAULT = 8;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational grant: a locked owner keeps the bus while it stays valid,
// otherwise a single valid wins and a tie goes to the port not served last.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  input  arb_state_e state_i,
  output logic       gnt0_o,
  output logic       gnt1_o
);

  // Pick at most one port; an owner that dropped valid falls through to open arbitration.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (state_i == OWN0 && valid0_i) begin
      gnt0_o = 1'b1;
    end else if (state_i == OWN1 && valid1_i) begin
      gnt1_o = 1'b1;
    end else if (valid0_i && valid1_i) begin
      gnt0_o = (last_grant_i == PORT_LDR);
      gnt1_o = (last_grant_i == PORT_CORE);
    end else begin
      gnt0_o = valid0_i;
      gnt1_o = valid1_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory, with
// capped locked bursts and one registered response per accepted access.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_lock,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_lock,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CntW-1:0] count_q, count_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic          hs0, hs1;
  logic [CntW-1:0] count_base;
  logic [31:0]   beats_next;
  logic          hs_lock;

  dmem_rr_pick u_pick (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .state_i      (state_q),
    .gnt0_o       (hs0),
    .gnt1_o       (hs1)
  );

  // Handshake outputs and memory bus; suppressed while reset is held.
  always_comb begin
    req0_ready = hs0 & rst;
    req1_ready = hs1 & rst;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    if (hs0 && rst) begin
      mem_we = req0_we;
      mem_a  = req0_addr;
      mem_wd = req0_wdata;
    end else if (hs1 && rst) begin
      mem_we = req1_we;
      mem_a  = req1_addr;
      mem_wd = req1_wdata;
    end
  end

  // Ownership and beat counting; any beat without a continuing lock releases the bus.
  always_comb begin
    state_d      = IDLE;
    count_d      = '0;
    last_grant_d = last_grant_q;
    hs_lock      = hs1 ? req1_lock : req0_lock;
    // A beat only extends the current burst when the owner itself is served.
    count_base   = ((state_q == OWN0 && hs0) || (state_q == OWN1 && hs1)) ? count_q : '0;
    beats_next   = 32'(count_base) + 32'd1;
    if (hs0 || hs1) begin
      last_grant_d = hs1 ? PORT_LDR : PORT_CORE;
      if (hs_lock && beats_next < MAX_BURST) begin
        state_d = hs1 ? OWN1 : OWN0;
        count_d = CntW'(beats_next);
      end
    end
  end

  // Response capture: reads return the memory word, writes return zero.
  always_comb begin
    rsp0_valid_d = hs0;
    rsp1_valid_d = hs1;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (hs0) rsp0_rdata_d = req0_we ? '0 : mem_rd;
    if (hs1) rsp1_rdata_d = req1_we ? '0 : mem_rd;
  end

  // State registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_LDR;
      count_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, corner sequences, and random
// traffic against an ownership/round-robin reference model.
module tb_dmem_arbiter;

  localparam int MB = 8;

  typedef struct {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
  } req_t;

  typedef struct {
    req_t        p0;
    req_t        p1;
    logic        rdy0;
    logic        rdy1;
    logic        mwe;
    logic [31:0] ma;
    logic        r0v;
    logic [31:0] r0d;
    logic        r1v;
    logic [31:0] r1d;
  } row_t;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .DW        (32),
    .AW        (32),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_lock  (req0_lock),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_lock  (req1_lock),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench memory: 256 words, unwritten words read as 0xA0000000 | index.
  bit [31:0]  mem [256];
  bit [255:0] written;

  always @(posedge clk) begin
    if (mem_we && mem_a[31:8] == 24'd0) begin
      mem[mem_a[7:0]]     <= mem_wd;
      written[mem_a[7:0]] <= 1'b1;
    end
  end

  function automatic logic [31:0] tb_word(input int i);
    return written[i] ? mem[i] : (32'hA000_0000 | 32'(i));
  endfunction

  assign mem_rd = (mem_a[31:8] == 24'd0) ? tb_word(int'(mem_a[7:0])) : 32'h0;

  // Reference model: current owner (-1 = none), beats served in the burst,
  // last served port, pending responses and a shadow memory.
  int          m_owner, m_beats, m_last;
  logic        m_pv0, m_pv1;
  logic [31:0] m_pd0, m_pd1;
  logic [31:0] mm [256];

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = 1;
    m_pv0   = 1'b0;
    m_pv1   = 1'b0;
    m_pd0   = '0;
    m_pd1   = '0;
    for (int i = 0; i < 256; i++) mm[i] = tb_word(i);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic v, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic l);
    req_t r;
    r.valid = v;
    r.we    = we;
    r.addr  = a;
    r.wdata = d;
    r.lock  = l;
    return r;
  endfunction

  function automatic req_t gen();
    return mk(($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0),
              32'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0));
  endfunction

  task automatic drive(input req_t a, input req_t b);
    req0_valid = a.valid; req0_we = a.we; req0_addr = a.addr;
    req0_wdata = a.wdata; req0_lock = a.lock;
    req1_valid = b.valid; req1_we = b.we; req1_addr = b.addr;
    req1_wdata = b.wdata; req1_lock = b.lock;
  endtask

  // One cycle against the model; g returns the port the model expects granted.
  task automatic step(input req_t a, input req_t b, output int g);
    req_t r;
    int   base;
    @(negedge clk);
    chk("rsp0_valid", rsp0_valid, m_pv0);
    if (m_pv0) chk("rsp0_rdata", rsp0_rdata, m_pd0);
    chk("rsp1_valid", rsp1_valid, m_pv1);
    if (m_pv1) chk("rsp1_rdata", rsp1_rdata, m_pd1);
    drive(a, b);
    #1;
    g = -1;
    if (m_owner == 0 && a.valid) g = 0;
    else if (m_owner == 1 && b.valid) g = 1;
    else if (a.valid && b.valid) g = 1 - m_last;
    else if (a.valid) g = 0;
    else if (b.valid) g = 1;
    r = (g == 1) ? b : a;
    chk("req0_ready", req0_ready, (g == 0));
    chk("req1_ready", req1_ready, (g == 1));
    chk("mem_we", mem_we, (g >= 0) && r.we);
    chk("mem_a", mem_a, (g >= 0) ? r.addr : 32'h0);
    chk("mem_wd", mem_wd, (g >= 0) ? r.wdata : 32'h0);
    m_pv0 = (g == 0);
    m_pv1 = (g == 1);
    if (g >= 0) begin
      if (g == 0) m_pd0 = r.we ? 32'h0 : mm[r.addr[7:0]];
      else        m_pd1 = r.we ? 32'h0 : mm[r.addr[7:0]];
      if (r.we) mm[r.addr[7:0]] = r.wdata;
      m_last = g;
      base   = (m_owner == g) ? m_beats : 0;
      if (r.lock && base + 1 < MB) begin
        m_owner = g;
        m_beats = base + 1;
      end else begin
        m_owner = -1;
        m_beats = 0;
      end
    end else begin
      m_owner = -1;
      m_beats = 0;
    end
  endtask

  task automatic do_reset(input logic v0_during);
    req_t idle;
    idle = mk(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(v0_during, 1'b1, 32'd3, 32'h1234, 1'b0), idle);
    #1;
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset req0_ready", req0_ready, 1'b0);
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset rsp0_valid", rsp0_valid, 1'b0);
    chk("reset rsp1_valid", rsp1_valid, 1'b0);
    chk("reset rsp0_rdata", rsp0_rdata, 32'h0);
    chk("reset rsp1_rdata", rsp1_rdata, 32'h0);
    repeat (2) @(negedge clk);
    drive(idle, idle);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic apply_row(input row_t t, input int idx);
    string s;
    s = $sformatf("row%0d", idx);
    @(negedge clk);
    chk({s, " rsp0_valid"}, rsp0_valid, t.r0v);
    if (t.r0v) chk({s, " rsp0_rdata"}, rsp0_rdata, t.r0d);
    chk({s, " rsp1_valid"}, rsp1_valid, t.r1v);
    if (t.r1v) chk({s, " rsp1_rdata"}, rsp1_rdata, t.r1d);
    drive(t.p0, t.p1);
    #1;
    chk({s, " req0_ready"}, req0_ready, t.rdy0);
    chk({s, " req1_ready"}, req1_ready, t.rdy1);
    chk({s, " mem_we"}, mem_we, t.mwe);
    chk({s, " mem_a"}, mem_a, t.ma);
  endtask

  function automatic row_t mkrow(input req_t a, input req_t b, input logic r0, input logic r1,
                                 input logic mwe, input logic [31:0] ma,
                                 input logic v0, input logic [31:0] d0,
                                 input logic v1, input logic [31:0] d1);
    row_t t;
    t.p0 = a; t.p1 = b; t.rdy0 = r0; t.rdy1 = r1; t.mwe = mwe; t.ma = ma;
    t.r0v = v0; t.r0d = d0; t.r1v = v1; t.r1d = d1;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t  tbl [9];
    req_t  idle, wr5, rd5, rd7, p0, p1, c0, c1;
    int    g, nb;
    int    q [$];

    idle = mk(0, 0, 0, 0, 0);
    wr5  = mk(1, 1, 32'd5, 32'hDEADBEEF, 0);
    rd5  = mk(1, 0, 32'd5, 32'h0, 0);
    rd7  = mk(1, 0, 32'd7, 32'h0, 0);
    // Write/read-back on port 0, then both ports reading: grants alternate.
    tbl[0] = mkrow(wr5,  idle, 1, 0, 1, 32'd5, 0, 0, 0, 0);
    tbl[1] = mkrow(rd5,  idle, 1, 0, 0, 32'd5, 1, 32'h0, 0, 0);
    tbl[2] = mkrow(idle, idle, 0, 0, 0, 32'd0, 1, 32'hDEADBEEF, 0, 0);
    tbl[3] = mkrow(rd5,  rd7,  0, 1, 0, 32'd7, 0, 0, 0, 0);
    tbl[4] = mkrow(rd5,  rd7,  1, 0, 0, 32'd5, 0, 0, 1, 32'hA000_0007);
    tbl[5] = mkrow(rd5,  rd7,  0, 1, 0, 32'd7, 1, 32'hDEADBEEF, 0, 0);
    tbl[6] = mkrow(rd5,  rd7,  1, 0, 0, 32'd5, 0, 0, 1, 32'hA000_0007);
    tbl[7] = mkrow(idle, idle, 0, 0, 0, 32'd0, 1, 32'hDEADBEEF, 0, 0);
    tbl[8] = mkrow(idle, idle, 0, 0, 0, 32'd0, 0, 0, 0, 0);

    rst = 1'b0;
    drive(idle, idle);
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) apply_row(tbl[i], i);

    // Locked burst on port 1 while port 0 waits: 8 beats, 1 for port 0, then port 1.
    do_reset(1'b0);
    p1 = mk(1, 0, 32'd16, 32'h0, 1);
    step(idle, p1, g);
    chk("burst first grant", 32'(g), 32'd1);
    nb = 1;
    p1.addr++;
    p0 = mk(1, 0, 32'd32, 32'h0, 0);
    for (int i = 0; i < 30 && nb < 12; i++) begin
      step(p0, p1, g);
      q.push_back(g);
      if (g == 1) begin
        nb++;
        p1.addr++;
      end
      if (g == 0) p0.addr++;
    end
    chk("burst beats done", 32'(nb), 32'd12);
    if (q.size() >= 9) begin
      nb = 0;
      for (int i = 0; i < 7; i++) if (q[i] == 1) nb++;
      chk("burst port1 beats", 32'(nb), 32'd7);
      chk("burst port0 slot", 32'(q[7]), 32'd0);
      chk("burst port1 resume", 32'(q[8]), 32'd1);
    end else begin
      chk("burst length", 32'(q.size()), 32'd9);
    end

    // Locked owner drops valid: port 0 is served in that same cycle.
    do_reset(1'b0);
    step(idle, mk(1, 0, 32'd30, 32'h0, 1), g);
    step(mk(1, 0, 32'd31, 32'h0, 0), idle, g);
    chk("drop grant port0", 32'(g), 32'd0);
    step(idle, idle, g);

    // Reset right after a locked read handshake drops the response and ownership.
    do_reset(1'b0);
    step(idle, mk(1, 0, 32'd40, 32'h0, 1), g);
    do_reset(1'b0);
    step(mk(1, 0, 32'd41, 32'h0, 0), mk(1, 0, 32'd42, 32'h0, 0), g);
    chk("post-reset tie to port0", 32'(g), 32'd0);
    step(idle, idle, g);

    // Random traffic with request hold while waiting.
    do_reset(1'b0);
    c0 = gen();
    c1 = gen();
    for (int i = 0; i < 400; i++) begin
      step(c0, c1, g);
      if (!(c0.valid && g != 0)) c0 = gen();
      if (!(c1.valid && g != 1)) c1 = gen();
    end
    step(idle, idle, g);
    step(idle, idle, g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
